// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder sequencer driving one shared external 4-bit adder.
// Ports:
//   start_valid/start_ready, op_a/op_b/op_cin : request side
//   add_a/add_b/add_cin -> add_sum/add_cout   : external adder
//   res_valid/res_ready, result/res_cout      : result side
//   busy                                      : high in RUN or DONE
// Optional macro NIBBLE_SERIAL_OVF_EN adds res_ovf,
// the two's-complement overflow of the wide sum.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   op_cin,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   res_cout,
`ifdef NIBBLE_SERIAL_OVF_EN
   output logic                   res_ovf,
`endif
   output logic                   busy
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   // Bit offset of the active nibble
   logic [IDXW+1:0] sel;
   assign sel = {idx_q, 2'b00};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      cout_d      = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_d       = ovf_q;
`endif
      add_a       = 4'h0;
      add_b       = 4'h0;
      add_cin     = 1'b0;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               a_d      = op_a;
               b_d      = op_b;
               carry_d  = op_cin;
               result_d = '0;
               cout_d   = 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
               ovf_d    = 1'b0;
`endif
               idx_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            add_a   = a_q[sel +: 4];
            add_b   = b_q[sel +: 4];
            add_cin = carry_q;
            result_d[sel +: 4] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST) begin
               cout_d  = add_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
               // Sign bits agree but the MSB nibble's sum sign differs
               ovf_d   = (a_q[W-1] == b_q[W-1]) &
                         (add_sum[3] != a_q[W-1]);
`endif
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign result   = result_q;
   assign res_cout = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
   assign res_ovf  = ovf_q;
`endif

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs a wide addition (4*NIBBLES bits) on one shared external 4-bit adder, one nibble per clock, LSB nibble first.
- Owns operand/result registers, the inter-nibble carry register and a valid/ready handshake on both sides.
- The adder itself stays combinational outside this block, connected via the add_* ports.
- Sits between a requesting datapath and the team's 4-bit ripple-carry adder instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (>=1); operand width W = 4*NIBBLES

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start_valid  input  1  request carries valid operands
start_ready  output  1  block can accept a request
op_a  input  W  operand A
op_b  input  W  operand B
op_cin  input  1  carry-in for the whole addition
add_a  output  4  nibble of A to the external adder
add_b  output  4  nibble of B to the external adder
add_cin  output  1  carry to the external adder
add_sum  input  4  adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  adder carry-out
res_valid  output  1  result/res_cout valid
res_ready  input  1  consumer accepts result
result  output  W  wide sum
res_cout  output  1  carry-out of MSB nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rstn=0, async): state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=result=0, res_cout=0, res_valid=0, start_ready=1, busy=0. Takes effect immediately, including mid-RUN or mid-DONE. The in-flight operation is discarded and no result is produced.
- States: IDLE, RUN, DONE. start_ready=1 only in IDLE. res_valid=1 only in DONE.
- IDLE:
  - On start_valid & start_ready at a clock edge: latch op_a->a_reg, op_b->b_reg, op_cin->carry_reg, clear result and res_cout, idx=0, go to RUN.
  - add_a/add_b/add_cin drive 0 in IDLE.
- RUN:
  - add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg.
  - Each edge: result[4*idx+:4]<=add_sum, carry_reg<=add_cout, idx<=idx+1.
  - On the edge with idx==NIBBLES-1: additionally res_cout<=add_cout, idx<=0, go to DONE.
- DONE:
  - Hold result/res_cout stable and drive add_* to 0.
  - On res_valid & res_ready: go to IDLE. start_ready rises the following cycle; no same-cycle accept in DONE.
- Latency: request accepted at edge k -> res_valid high after edge k+NIBBLES (NIBBLES=1: one RUN cycle). Throughput is one operation per NIBBLES+2 cycles with res_ready held high.
- Arithmetic: {res_cout,result} = op_a + op_b + op_cin, unsigned, W+1 bits, no saturation. Wrap-around is reported only via res_cout.
- start_valid outside IDLE is ignored; operands are not resampled. op_a/op_b/op_cin may change freely after acceptance.
- idx width is clog2(NIBBLES), minimum 1. idx never exceeds NIBBLES-1.
- result is readable at any time but is only guaranteed when res_valid=1.

Optional Feature:
NIBBLE_SERIAL_OVF_EN:
- Defined: adds output res_ovf (1 bit), the two's-complement overflow of the W-bit addition = (a_reg[W-1]==b_reg[W-1]) & (add_sum[3]!=a_reg[W-1]), captured on the final RUN edge.
  - Reset value 0, cleared on accept, valid with res_valid, held in DONE.
- Not defined: port res_ovf and its register are absent. All other behaviour is identical.

Test Plan:
- Basic add: op_a=16'h1234, op_b=16'h4321, op_cin=0 -> res_valid exactly 4 cycles after accept, result=16'h5555, res_cout=0; add_a walks 4,3,2,1.
- Full ripple: op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> result=16'h0000, res_cout=1; add_cin=0,1,1,1 across RUN cycles.
- Carry-in path: op_a=16'hFFFF, op_b=16'h0000, op_cin=1 -> result=16'h0000, res_cout=1.
- Backpressure: res_ready=0 for 5 cycles in DONE with start_valid=1 and new operands -> result/res_valid held, start_ready=0, no re-accept. res_ready=1 -> IDLE next cycle, then the new request is accepted.
- Reset mid-op: assert rstn=0 asynchronously at RUN idx=2 -> all outputs at reset values immediately, no res_valid after release. A new request 16'h0F0F+16'h00F1 then gives 16'h1000, res_cout=0.
- Overflow (NIBBLE_SERIAL_OVF_EN defined): 16'h7FFF+16'h0001 -> result=16'h8000, res_ovf=1, res_cout=0. 16'h8000+16'h8000 -> result=0, res_ovf=1, res_cout=1.
